// File: rtl/sequence_store.sv
// sequence_store: an append-only colour sequence memory with registered
// playback. The player checker is built only when SEQUENCE_STORE_CHECK_EN
// is defined.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   load_colour, new_colour - append a colour at slot[length]
//   rd_start, rd_next     - start playback at slot 0 / advance one entry
//   rd_colour, rd_valid, rd_last - registered playback output and flags
//   length, full, empty   - fill level and its derived flags
//   overflow              - sticky flag: an append was attempted while full
//   chk_valid, chk_colour - player entry to compare (checker build only)
//   chk_match, chk_miss, chk_done - one-cycle checker result pulses
module sequence_store #(
    parameter int DEPTH    = 32,
    parameter int COLOUR_W = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_colour,
    input  logic [COLOUR_W-1:0]        new_colour,
    input  logic                       rd_start,
    input  logic                       rd_next,
    output logic [COLOUR_W-1:0]        rd_colour,
    output logic                       rd_valid,
    output logic                       rd_last,
    output logic [$clog2(DEPTH+1)-1:0] length,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
`ifdef SEQUENCE_STORE_CHECK_EN
    ,
    input  logic                       chk_valid,
    input  logic [COLOUR_W-1:0]        chk_colour,
    output logic                       chk_match,
    output logic                       chk_miss,
    output logic                       chk_done
`endif
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PLAY = 1'b1;

    logic [COLOUR_W-1:0] mem_q [DEPTH];
    logic [LW-1:0]       length_q, length_d;
    logic                ovf_q, ovf_d;
    logic [0:0]          state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [LW-1:0]       snap_q, snap_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                accept;
    logic                last;

    assign full     = (length_q == LW'(DEPTH));
    assign empty    = (length_q == '0);
    assign length   = length_q;
    assign overflow = ovf_q;
    assign rd_valid = (state_q == PLAY);
    assign rd_colour = colour_q;

    // Compare in the wider count domain so a snapshot of DEPTH works.
    assign last    = (state_q == PLAY) && (LW'(idx_q) == snap_q - LW'(1));
    assign rd_last = last;

    assign accept = load_colour && !full;

    always_comb begin
        length_d = length_q;
        ovf_d    = ovf_q;
        if (accept) begin
            length_d = length_q + LW'(1);
        end
        if (load_colour && full) begin
            ovf_d = 1'b1;
        end
    end

    // Playback only ever reads slots below the snapshot, so it never races
    // an append, which writes at slot[length] >= snapshot.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        snap_d   = snap_q;
        colour_d = colour_q;
        if (rd_start && !empty) begin
            state_d  = PLAY;
            idx_d    = '0;
            snap_d   = length_q;
            colour_d = mem_q[0];
        end else if (state_q == PLAY && rd_next) begin
            if (last) begin
                state_d = IDLE;
            end else begin
                idx_d    = idx_q + IW'(1);
                colour_d = mem_q[idx_q + IW'(1)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            length_q <= '0;
            ovf_q    <= 1'b0;
            state_q  <= IDLE;
            idx_q    <= '0;
            snap_q   <= '0;
            colour_q <= '0;
        end else begin
            if (accept) begin
                mem_q[length_q[IW-1:0]] <= new_colour;
            end
            length_q <= length_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            idx_q    <= idx_d;
            snap_q   <= snap_d;
            colour_q <= colour_d;
        end
    end

`ifdef SEQUENCE_STORE_CHECK_EN
    logic [IW-1:0] chk_ptr_q, chk_ptr_d;
    logic          match_q, match_d;
    logic          miss_q, miss_d;
    logic          done_q, done_d;
    logic          chk_en;
    logic          chk_hit;
    logic          chk_end;

    assign chk_en  = chk_valid && (state_q == IDLE) && !empty;
    assign chk_hit = (chk_colour == mem_q[chk_ptr_q]);
    assign chk_end = (LW'(chk_ptr_q) == length_q - LW'(1));

    always_comb begin
        chk_ptr_d = chk_ptr_q;
        match_d   = 1'b0;
        miss_d    = 1'b0;
        done_d    = 1'b0;
        if (chk_en) begin
            if (chk_hit) begin
                match_d = 1'b1;
                if (chk_end) begin
                    done_d    = 1'b1;
                    chk_ptr_d = '0;
                end else begin
                    chk_ptr_d = chk_ptr_q + IW'(1);
                end
            end else begin
                miss_d    = 1'b1;
                chk_ptr_d = '0;
            end
        end
        // A new entry changes the sequence, so the player starts over.
        if (accept) begin
            chk_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chk_ptr_q <= '0;
            match_q   <= 1'b0;
            miss_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            chk_ptr_q <= chk_ptr_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            done_q    <= done_d;
        end
    end

    assign chk_match = match_q;
    assign chk_miss  = miss_q;
    assign chk_done  = done_q;
`endif

endmodule

// File: tb/tb_sequence_store.sv
// Randomised bench for sequence_store, compared cycle by cycle against a
// queue-based reference model; directed sequences cover the corner cases.
module tb_sequence_store;

    localparam int DEPTH = 32;
    localparam int CW    = 2;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_colour = 1'b0;
    logic [CW-1:0] new_colour = '0;
    logic          rd_start = 1'b0;
    logic          rd_next = 1'b0;
    logic [CW-1:0] rd_colour;
    logic          rd_valid;
    logic          rd_last;
    logic [LW-1:0] length;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          chk_valid = 1'b0;
    logic [CW-1:0] chk_colour = '0;
`ifdef SEQUENCE_STORE_CHECK_EN
    logic          chk_match;
    logic          chk_miss;
    logic          chk_done;
`endif

    sequence_store #(.DEPTH(DEPTH), .COLOUR_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_colour(load_colour),
        .new_colour (new_colour),
        .rd_start   (rd_start),
        .rd_next    (rd_next),
        .rd_colour  (rd_colour),
        .rd_valid   (rd_valid),
        .rd_last    (rd_last),
        .length     (length),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow)
`ifdef SEQUENCE_STORE_CHECK_EN
        ,
        .chk_valid  (chk_valid),
        .chk_colour (chk_colour),
        .chk_match  (chk_match),
        .chk_miss   (chk_miss),
        .chk_done   (chk_done)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [CW-1:0] mq[$];
    bit            m_ovf;
    bit            m_play;
    int            m_idx;
    int            m_snap;
    logic [CW-1:0] m_col;
    int            m_ptr;
    bit            m_match, m_miss, m_done;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf   = 0;
        m_play  = 0;
        m_idx   = 0;
        m_snap  = 0;
        m_col   = '0;
        m_ptr   = 0;
        m_match = 0;
        m_miss  = 0;
        m_done  = 0;
    endtask

    task automatic model_step(bit ld, logic [CW-1:0] c, bit rs, bit rn,
                              bit rst, bit cv, logic [CW-1:0] cc);
        if (rst) begin
            model_reset();
            return;
        end
        m_match = 0;
        m_miss  = 0;
        m_done  = 0;
        if (cv && !m_play && mq.size() > 0) begin
            if (cc == mq[m_ptr]) begin
                m_match = 1;
                if (m_ptr == mq.size() - 1) begin
                    m_done = 1;
                    m_ptr  = 0;
                end else begin
                    m_ptr++;
                end
            end else begin
                m_miss = 1;
                m_ptr  = 0;
            end
        end
        if (rs && mq.size() > 0) begin
            m_play = 1;
            m_idx  = 0;
            m_snap = mq.size();
            m_col  = mq[0];
        end else if (m_play && rn) begin
            if (m_idx == m_snap - 1) begin
                m_play = 0;
            end else begin
                m_idx++;
                m_col = mq[m_idx];
            end
        end
        if (ld) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(c);
                m_ptr = 0;
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic compare_all();
        check("length", 32'(length), 32'(mq.size()));
        check("empty", 32'(empty), 32'(mq.size() == 0));
        check("full", 32'(full), 32'(mq.size() == DEPTH));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("rd_valid", 32'(rd_valid), 32'(m_play));
        check("rd_last", 32'(rd_last), 32'(m_play && m_idx == m_snap - 1));
        check("rd_colour", 32'(rd_colour), 32'(m_col));
`ifdef SEQUENCE_STORE_CHECK_EN
        check("chk_match", 32'(chk_match), 32'(m_match));
        check("chk_miss", 32'(chk_miss), 32'(m_miss));
        check("chk_done", 32'(chk_done), 32'(m_done));
`endif
    endtask

    task automatic step(bit ld, logic [CW-1:0] c, bit rs, bit rn,
                        bit rst, bit cv, logic [CW-1:0] cc);
        reset       = rst;
        load_colour = ld;
        new_colour  = c;
        rd_start    = rs;
        rd_next     = rn;
        chk_valid   = cv;
        chk_colour  = cc;
        model_step(ld, c, rs, rn, rst, cv, cc);
        @(posedge clk);
        #1;
        reset       = 0;
        load_colour = 0;
        rd_start    = 0;
        rd_next     = 0;
        chk_valid   = 0;
        compare_all();
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 1, 0, 0);
    endtask
    task automatic append(logic [CW-1:0] c);
        step(1, c, 0, 0, 0, 0, 0);
    endtask
    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    logic [CW-1:0] seq4 [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [CW-1:0] last_written;

    initial begin
        model_reset();
        #2;
        // Reset state
        do_reset();
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_last", 32'(rd_last), 32'd0);
        check("rst_rd_colour", 32'(rd_colour), 32'd0);

        // Basic append and playback
        for (int i = 0; i < 4; i++) append(seq4[i]);
        check("basic_len", 32'(length), 32'd4);
        check("basic_empty", 32'(empty), 32'd0);
        step(0, 0, 1, 0, 0, 0, 0);
        check("pb_col0", 32'(rd_colour), 32'(seq4[0]));
        check("pb_last0", 32'(rd_last), 32'd0);
        for (int i = 1; i < 4; i++) begin
            step(0, 0, 0, 1, 0, 0, 0);
            check("pb_col", 32'(rd_colour), 32'(seq4[i]));
            check("pb_last", 32'(rd_last), 32'(i == 3));
        end
        step(0, 0, 0, 1, 0, 0, 0);
        check("pb_end_valid", 32'(rd_valid), 32'd0);
        check("pb_hold_col", 32'(rd_colour), 32'd0);

        // Fill to DEPTH, then overflow
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            last_written = CW'($urandom);
            append(last_written);
        end
        append(~last_written);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_len", 32'(length), 32'(DEPTH));
        check("ovf_flag", 32'(overflow), 32'd1);
        step(0, 0, 1, 0, 0, 0, 0);
        for (int i = 1; i < DEPTH; i++) step(0, 0, 0, 1, 0, 0, 0);
        check("ovf_slot31", 32'(rd_colour), 32'(last_written));
        check("ovf_slot31_last", 32'(rd_last), 32'd1);

        // Append during playback does not extend it
        do_reset();
        for (int i = 0; i < 3; i++) append(CW'(i + 1));
        step(0, 0, 1, 0, 0, 0, 0);
        step(1, 2, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        check("ext_last", 32'(rd_last), 32'd1);
        step(0, 0, 0, 1, 0, 0, 0);
        check("ext_end", 32'(rd_valid), 32'd0);
        check("ext_len", 32'(length), 32'd4);

        // Reset in the middle of playback
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        append(3);
        append(3);
        do_reset();
        check("midrst_valid", 32'(rd_valid), 32'd0);
        check("midrst_len", 32'(length), 32'd0);
        check("midrst_ovf", 32'(overflow), 32'd0);

        // rd_start while empty is ignored
        step(0, 0, 1, 0, 0, 1, 1);
        check("empty_start", 32'(rd_valid), 32'd0);
`ifdef SEQUENCE_STORE_CHECK_EN
        check("empty_chk", 32'({chk_match, chk_miss, chk_done}), 32'd0);
        for (int i = 0; i < 3; i++) append(CW'(i + 1));
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 1, CW'(i + 1));
            check("chk_seq_match", 32'(chk_match), 32'd1);
            check("chk_seq_done", 32'(chk_done), 32'(i == 2));
        end
        step(0, 0, 0, 0, 0, 1, 1);
        check("chk_m1", 32'(chk_match), 32'd1);
        step(0, 0, 0, 0, 0, 1, 0);
        check("chk_miss", 32'(chk_miss), 32'd1);
        step(0, 0, 0, 0, 0, 1, 1);
        check("chk_ptr0", 32'(chk_match), 32'd1);
`endif

        // Randomised traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit            ld, rs, rn, rst, cv;
            logic [CW-1:0] c, cc;
            ld  = ($urandom_range(0, 2) == 0);
            c   = CW'($urandom);
            rs  = ($urandom_range(0, 15) == 0);
            rn  = ($urandom_range(0, 1) == 0);
            rst = ($urandom_range(0, 299) == 0);
            cv  = ($urandom_range(0, 2) == 0);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                cc = mq[m_ptr];
            else
                cc = CW'($urandom);
            step(ld, c, rs, rn, rst, cv, cc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
